// File: rtl/msrv32_trap_pkg.sv
// Shared definitions for the msrv32 machine-mode trap controller:
// FSM state encoding, trap cause codes and PC-mux select values.
package msrv32_trap_pkg;

    // Trap sequencer states
    typedef enum logic [1:0] {
        S_RESET       = 2'b00,
        S_OPERATING   = 2'b01,
        S_TRAP_TAKEN  = 2'b10,
        S_TRAP_RETURN = 2'b11
    } trap_state_e;

    // Next-PC select driven to the PC mux
    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_SEQ  = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_MEPC = 2'b11;

    // Interrupt cause codes (mcause with interrupt bit set)
    localparam int unsigned CAUSE_MSI = 3;
    localparam int unsigned CAUSE_MTI = 7;
    localparam int unsigned CAUSE_MEI = 11;

    // Exception cause codes (mcause with interrupt bit clear)
    localparam int unsigned CAUSE_INSTR_MISALIGNED = 0;
    localparam int unsigned CAUSE_ILLEGAL_INSTR    = 2;
    localparam int unsigned CAUSE_BREAKPOINT       = 3;
    localparam int unsigned CAUSE_LOAD_MISALIGNED  = 4;
    localparam int unsigned CAUSE_STORE_MISALIGNED = 6;
    localparam int unsigned CAUSE_ECALL_M          = 11;

endpackage : msrv32_trap_pkg

// File: rtl/msrv32_trap_prio.sv
// Combinational trap priority encoder. Resolves enabled interrupts and the
// exceptions of the completing instruction into a single {valid, i_or_e, cause}.
// Interrupts outrank exceptions so that an excepting instruction is simply
// not retired and re-executes after mret.
module msrv32_trap_prio
    import msrv32_trap_pkg::*;
#(
    parameter int CAUSE_W = 4
) (
    input  logic               i_instr_valid,
    input  logic               i_illegal_instr,
    input  logic               i_misaligned_instr,
    input  logic               i_misaligned_load,
    input  logic               i_misaligned_store,
    input  logic               i_ecall,
    input  logic               i_ebreak,
    input  logic               i_mie,
    input  logic               i_meie,
    input  logic               i_mtie,
    input  logic               i_msie,
    input  logic               i_meip,
    input  logic               i_mtip,
    input  logic               i_msip,
    output logic               o_irq_req,
    output logic               o_exc_req,
    output logic               o_valid,
    output logic               o_i_or_e,
    output logic [CAUSE_W-1:0] o_cause
);

    logic w_irq_mei;
    logic w_irq_msi;
    logic w_irq_mti;
    logic w_any_exc;

    // Each interrupt source is live only when globally and individually enabled
    assign w_irq_mei = i_mie & i_meie & i_meip;
    assign w_irq_msi = i_mie & i_msie & i_msip;
    assign w_irq_mti = i_mie & i_mtie & i_mtip;

    assign w_any_exc = i_misaligned_instr | i_illegal_instr | i_ebreak |
                       i_ecall | i_misaligned_load | i_misaligned_store;

    assign o_irq_req = w_irq_mei | w_irq_msi | w_irq_mti;
    assign o_exc_req = i_instr_valid & w_any_exc;
    assign o_valid   = o_irq_req | o_exc_req;

    // Fixed-priority selection of the winning cause
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path through the if/else chain leaves it unassigned (latch).
        o_i_or_e = 1'b0;
        o_cause  = '0;
        if (w_irq_mei) begin
            o_i_or_e = 1'b1;
            o_cause  = CAUSE_W'(CAUSE_MEI);
        end else if (w_irq_msi) begin
            o_i_or_e = 1'b1;
            o_cause  = CAUSE_W'(CAUSE_MSI);
        end else if (w_irq_mti) begin
            o_i_or_e = 1'b1;
            o_cause  = CAUSE_W'(CAUSE_MTI);
        end else if (i_instr_valid) begin
            if (i_misaligned_instr) begin
                o_cause = CAUSE_W'(CAUSE_INSTR_MISALIGNED);
            end else if (i_illegal_instr) begin
                o_cause = CAUSE_W'(CAUSE_ILLEGAL_INSTR);
            end else if (i_ebreak) begin
                o_cause = CAUSE_W'(CAUSE_BREAKPOINT);
            end else if (i_ecall) begin
                o_cause = CAUSE_W'(CAUSE_ECALL_M);
            end else if (i_misaligned_load) begin
                o_cause = CAUSE_W'(CAUSE_LOAD_MISALIGNED);
            end else if (i_misaligned_store) begin
                o_cause = CAUSE_W'(CAUSE_STORE_MISALIGNED);
            end
        end
    end

endmodule : msrv32_trap_prio

// File: rtl/msrv32_trap_controller.sv
// Machine-mode trap sequencer for the msrv32 core. Detects traps and mret in
// S_OPERATING, then spends one cycle strobing the CSR file (trap entry or
// return) while steering the PC mux and flushing the in-flight instruction.
// Holds no CSR state of its own beyond the latched cause of the current trap.
module msrv32_trap_controller
    import msrv32_trap_pkg::*;
#(
    parameter int RESET_CYCLES = 1,
    parameter int CAUSE_W      = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               ready_in,
    input  logic               instr_valid_in,
    input  logic               illegal_instr_in,
    input  logic               misaligned_instr_in,
    input  logic               misaligned_load_in,
    input  logic               misaligned_store_in,
    input  logic               ecall_in,
    input  logic               ebreak_in,
    input  logic               mret_in,
    input  logic               mie_in,
    input  logic               meie_in,
    input  logic               mtie_in,
    input  logic               msie_in,
    input  logic               meip_in,
    input  logic               mtip_in,
    input  logic               msip_in,
    output logic               i_or_e_out,
    output logic [CAUSE_W-1:0] cause_out,
    output logic               set_epc_out,
    output logic               set_cause_out,
    output logic               mie_clear_out,
    output logic               mie_set_out,
    output logic               instret_inc_out,
    output logic               misaligned_exception_out,
    output logic [1:0]         pc_src_out,
    output logic               flush_out
);

    localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(RESET_CYCLES - 1);

    trap_state_e        r_state;
    trap_state_e        w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_i_or_e;
    logic [CAUSE_W-1:0] r_cause;

    logic               w_advance;
    logic               w_take_trap;
    logic               w_irq_req;
    logic               w_exc_req;
    logic               w_trap_valid;
    logic               w_trap_i_or_e;
    logic [CAUSE_W-1:0] w_trap_cause;

    // Strobes must stay low while reset is asserted, even though the state
    // register already sits in S_RESET; folding rst_n_in in here keeps the
    // boot-time flush from appearing during the reset pulse itself.
    assign w_advance = ready_in & rst_n_in;

    msrv32_trap_prio #(
        .CAUSE_W (CAUSE_W)
    ) u_prio (
        .i_instr_valid      (instr_valid_in),
        .i_illegal_instr    (illegal_instr_in),
        .i_misaligned_instr (misaligned_instr_in),
        .i_misaligned_load  (misaligned_load_in),
        .i_misaligned_store (misaligned_store_in),
        .i_ecall            (ecall_in),
        .i_ebreak           (ebreak_in),
        .i_mie              (mie_in),
        .i_meie             (meie_in),
        .i_mtie             (mtie_in),
        .i_msie             (msie_in),
        .i_meip             (meip_in),
        .i_mtip             (mtip_in),
        .i_msip             (msip_in),
        .o_irq_req          (w_irq_req),
        .o_exc_req          (w_exc_req),
        .o_valid            (w_trap_valid),
        .o_i_or_e           (w_trap_i_or_e),
        .o_cause            (w_trap_cause)
    );

    // A trap is accepted only from S_OPERATING on an advancing cycle
    assign w_take_trap = (r_state == S_OPERATING) & w_advance & w_trap_valid;

    // Cause reporting comes from the latch so it is stable through S_TRAP_TAKEN
    assign i_or_e_out = r_i_or_e;
    assign cause_out  = r_cause;

    // Misaligned indication is purely combinational on the completing instruction
    assign misaligned_exception_out = instr_valid_in &
        (misaligned_instr_in | misaligned_load_in | misaligned_store_in);

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n_in) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Boot delay counter: counts advancing cycles spent in S_RESET
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_count <= '0;
        end else if ((r_state == S_RESET) && ready_in && (r_count != LAST_COUNT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Capture the winning trap's type and cause at the edge it is accepted
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_i_or_e <= 1'b0;
            r_cause  <= '0;
        end else if (w_take_trap) begin
            r_i_or_e <= w_trap_i_or_e;
            r_cause  <= w_trap_cause;
        end
    end

    // Next-state and Moore/Mealy outputs; ready_in low freezes state and kills strobes
    always_comb begin
        w_next_state    = r_state;
        pc_src_out      = PC_SRC_BOOT;
        set_epc_out     = 1'b0;
        set_cause_out   = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b0;
        flush_out       = 1'b0;

        case (r_state)
            S_RESET: begin
                pc_src_out = PC_SRC_BOOT;
                flush_out  = w_advance;
                if (w_advance && (r_count == LAST_COUNT)) begin
                    w_next_state = S_OPERATING;
                end
            end

            S_OPERATING: begin
                pc_src_out      = PC_SRC_SEQ;
                instret_inc_out = w_advance & instr_valid_in &
                                  ~w_irq_req & ~w_exc_req & ~mret_in;
                if (w_advance) begin
                    if (w_trap_valid) begin
                        w_next_state = S_TRAP_TAKEN;
                    end else if (mret_in && instr_valid_in) begin
                        w_next_state = S_TRAP_RETURN;
                    end
                end
            end

            S_TRAP_TAKEN: begin
                pc_src_out    = PC_SRC_TRAP;
                set_epc_out   = w_advance;
                set_cause_out = w_advance;
                mie_clear_out = w_advance;
                flush_out     = w_advance;
                if (w_advance) begin
                    w_next_state = S_OPERATING;
                end
            end

            S_TRAP_RETURN: begin
                pc_src_out      = PC_SRC_MEPC;
                mie_set_out     = w_advance;
                flush_out       = w_advance;
                instret_inc_out = w_advance;
                if (w_advance) begin
                    w_next_state = S_OPERATING;
                end
            end

            default: begin
                w_next_state = S_RESET;
            end
        endcase
    end

endmodule : msrv32_trap_controller
